pll_dyn_ctrl: RTL and testbench



---
 rtl/pll_dyn_ctrl_pkg.sv | 47 ++++
 rtl/pll_dyn_ctrl_if.sv | 12 +
 rtl/pll_dyn_ctrl.sv | 138 +++++++++++++
 tb/tb_pll_dyn_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pll_dyn_ctrl_pkg.sv
// Package for the rPLL dynamic divider controller.
// Holds the FSM state encoding, the preset table of {IDIV, FBDIV} pairs and
// the helper that turns a preset index into Gowin IDSEL/FBDSEL codes.
// Output frequency is 27 MHz * (FBDIV+1)/(IDIV+1). ODIV=4 is fixed, so the
// VCO runs at 4*fout, and every preset keeps the VCO inside 400..600 MHz.
package pll_dyn_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_HOLD   = 2'd1;
    localparam state_t ST_APPLY  = 2'd2;
    localparam state_t ST_SETTLE = 2'd3;

    typedef struct packed {
        logic [5:0] idiv;
        logic [5:0] fbdiv;
    } preset_t;

    typedef struct packed {
        logic [5:0] idsel;
        logic [5:0] fbdsel;
    } codes_t;

    localparam int TABLE_SIZE = 4;

    // 0: 126 MHz, 1: 108 MHz, 2: 144 MHz, 3: 135 MHz
    localparam preset_t PRESETS [TABLE_SIZE] = '{
        '{idiv: 6'd2, fbdiv: 6'd13},
        '{idiv: 6'd0, fbdiv: 6'd3},
        '{idiv: 6'd2, fbdiv: 6'd15},
        '{idiv: 6'd0, fbdiv: 6'd4}
    };

    // Gowin dynamic select codes are the one's complement of the divider.
    // Indices outside the table fall back to preset 0; the controller never
    // applies one, the guard only keeps the lookup total.
    function automatic codes_t preset_codes(input logic [2:0] sel);
        preset_t p;
        codes_t  c;
        p        = (sel < 3'(TABLE_SIZE)) ? PRESETS[sel[1:0]] : PRESETS[0];
        c.idsel  = 6'd63 - p.idiv;
        c.fbdsel = 6'd63 - p.fbdiv;
        return c;
    endfunction

endpackage

// File: rtl/pll_dyn_ctrl_if.sv
// Request handshake between software/bus logic and the PLL controller.
//   req_valid  request strobe (master -> slave)
//   req_sel    requested preset index (master -> slave)
//   req_ready  controller idle and able to accept (slave -> master)
interface pll_dyn_ctrl_if;
    logic       req_valid;
    logic [2:0] req_sel;
    logic       req_ready;

    modport master (output req_valid, output req_sel, input req_ready);
    modport slave  (input req_valid, input req_sel, output req_ready);
endinterface

// File: rtl/pll_dyn_ctrl.sv
// Runtime frequency switch for a Gowin rPLL with dynamic IDIV/FBDIV.
// Runs in the 27 MHz reference domain. A change goes through
// HOLD (clk_hold warning to downstream) -> APPLY (codes load) -> SETTLE
// (fixed relock wait, since lock is not exported) -> IDLE with a done pulse.
// Ports:
//   clk, rst_n     27 MHz reference clock, synchronous active-low reset
//   bus            request handshake (slave side)
//   idsel, fbdsel  registered rPLL divider select codes
//   cur_sel        preset currently applied
//   clk_hold       PLL output untrustworthy
//   busy           change in progress
//   done, err      one-cycle completion / rejection pulses
module pll_dyn_ctrl
    import pll_dyn_pkg::*;
#(
    parameter int NUM_PRESETS   = 4,
    parameter int HOLD_CYCLES   = 8,
    parameter int SETTLE_CYCLES = 27000,
    parameter int CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pll_dyn_ctrl_if.slave        bus,
    output logic [5:0]           idsel,
    output logic [5:0]           fbdsel,
    output logic [2:0]           cur_sel,
    output logic                 clk_hold,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam codes_t RST_CODES = preset_codes(3'd0);

    state_t     state_q,  state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0] pend_q,   pend_d;
    logic [2:0] cur_q,    cur_d;
    logic [5:0] idsel_q,  idsel_d;
    logic [5:0] fbdsel_q, fbdsel_d;
    logic       done_q,   done_d;
    logic       err_q,    err_d;

    logic   accept;
    codes_t pend_codes;

    assign accept     = bus.req_valid && (state_q == ST_IDLE);
    assign pend_codes = preset_codes(pend_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        cur_d    = cur_q;
        idsel_d  = idsel_q;
        fbdsel_d = fbdsel_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (int'(bus.req_sel) >= NUM_PRESETS) begin
                        err_d = 1'b1;
                    end else if (bus.req_sel == cur_q) begin
                        // Already running there: acknowledge without a relock.
                        done_d = 1'b1;
                    end else begin
                        pend_d  = bus.req_sel;
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                    state_d = ST_APPLY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_APPLY: begin
                // Both codes load on the same edge so the PLL never sees a
                // mixed IDIV/FBDIV pair.
                idsel_d  = pend_codes.idsel;
                fbdsel_d = pend_codes.fbdsel;
                cur_d    = pend_q;
                state_d  = ST_SETTLE;
                cnt_d    = '0;
            end
            default: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    // Reset restarts a full settle on preset 0, since the PLL itself may
    // have been mid-relock when reset hit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_SETTLE;
            cnt_q    <= '0;
            pend_q   <= 3'd0;
            cur_q    <= 3'd0;
            idsel_q  <= RST_CODES.idsel;
            fbdsel_q <= RST_CODES.fbdsel;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            cur_q    <= cur_d;
            idsel_q  <= idsel_d;
            fbdsel_q <= fbdsel_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    // Every non-idle state is a hold state, so clk_hold drops on the same
    // edge that raises done.
    assign clk_hold      = (state_q != ST_IDLE);
    assign idsel         = idsel_q;
    assign fbdsel        = fbdsel_q;
    assign cur_sel       = cur_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Self-checking bench for pll_dyn_ctrl. The settle time is shortened so the
// run stays short; every timing expectation is derived from the parameters.
module tb_pll_dyn_ctrl;

    localparam int NP = 4;
    localparam int H  = 8;
    localparam int S  = 500;

    logic clk;
    logic rst_n;
    logic [5:0] idsel, fbdsel;
    logic [2:0] cur_sel;
    logic clk_hold, busy, done, err;

    int ncmp  = 0;
    int nfail = 0;
    int exp_cur;

    // Preset table as divider values; codes are derived here from the rule
    // code = 63 - divider.
    int idiv_t  [NP] = '{2, 0, 2, 0};
    int fbdiv_t [NP] = '{13, 3, 15, 4};

    pll_dyn_ctrl_if bus ();

    pll_dyn_ctrl #(
        .NUM_PRESETS  (NP),
        .HOLD_CYCLES  (H),
        .SETTLE_CYCLES(S),
        .CNT_W        (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .idsel   (idsel),
        .fbdsel  (fbdsel),
        .cur_sel (cur_sel),
        .clk_hold(clk_hold),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_id(input int s);
        return 63 - idiv_t[s];
    endfunction

    function automatic int exp_fb(input int s);
        return 63 - fbdiv_t[s];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Counts cycles until done; expected to equal the settle length.
    task automatic wait_done(input string tag, input int expn);
        int n;
        n = 0;
        while (done !== 1'b1 && n < expn + 100) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, expn);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_hold"}, clk_hold, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ready"}, bus.req_ready, 1);
    endtask

    // Entered at cycle T+1 after acceptance of a change to preset s.
    task automatic follow_change(input int s, input bit tail);
        int old_cur;
        old_cur = exp_cur;
        chk("chg_hold", clk_hold, 1);
        chk("chg_busy", busy, 1);
        chk("chg_ready", bus.req_ready, 0);
        repeat (H - 1) tick();
        chk("chg_id_old", idsel, exp_id(old_cur));
        chk("chg_fb_old", fbdsel, exp_fb(old_cur));
        chk("chg_cur_old", cur_sel, old_cur);
        repeat (2) tick();
        chk("chg_id_new", idsel, exp_id(s));
        chk("chg_fb_new", fbdsel, exp_fb(s));
        chk("chg_cur_new", cur_sel, s);
        chk("chg_hold2", clk_hold, 1);
        exp_cur = s;
        // Done lands at T+2+H+S; we now stand at T+2+H.
        wait_done("chg", S);
        if (tail) begin
            tick();
            chk("chg_done_clr", done, 0);
        end
    endtask

    task automatic do_req(input int s);
        bus.req_valid = 1'b1;
        bus.req_sel   = 3'(s);
        tick();
        bus.req_valid = 1'b0;
        if (s >= NP) begin
            chk("rej_err", err, 1);
            chk("rej_done", done, 0);
            chk("rej_busy", busy, 0);
            chk("rej_hold", clk_hold, 0);
            chk("rej_id", idsel, exp_id(exp_cur));
            chk("rej_fb", fbdsel, exp_fb(exp_cur));
            chk("rej_cur", cur_sel, exp_cur);
            tick();
            chk("rej_err_clr", err, 0);
        end else if (s == exp_cur) begin
            chk("same_done", done, 1);
            chk("same_err", err, 0);
            chk("same_hold", clk_hold, 0);
            chk("same_busy", busy, 0);
            chk("same_id", idsel, exp_id(exp_cur));
            tick();
            chk("same_done_clr", done, 0);
            chk("same_hold2", clk_hold, 0);
        end else begin
            follow_change(s, 1'b1);
        end
    endtask

    initial begin
        int s;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_sel   = 3'd0;
        exp_cur       = 0;
        repeat (3) tick();
        chk("rst_id", idsel, 6'h3D);
        chk("rst_fb", fbdsel, 6'h32);
        chk("rst_cur", cur_sel, 0);
        chk("rst_hold", clk_hold, 1);
        chk("rst_busy", busy, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", bus.req_ready, 0);
        rst_n = 1'b1;
        wait_done("boot", S);
        chk("boot_id", idsel, 6'h3D);
        chk("boot_fb", fbdsel, 6'h32);
        tick();

        // Directed: same preset, real change, invalid index.
        do_req(0);
        do_req(2);
        chk("p2_id", idsel, 6'h3D);
        chk("p2_fb", fbdsel, 6'h30);
        do_req(5);

        // Request held high during a change is only taken once idle.
        bus.req_valid = 1'b1;
        bus.req_sel   = 3'd3;
        tick();
        bus.req_sel   = 3'd1;
        follow_change(3, 1'b0);
        chk("held_cur3", cur_sel, 3);
        tick();
        bus.req_valid = 1'b0;
        chk("held_done_clr", done, 0);
        follow_change(1, 1'b1);
        chk("held_id", idsel, 6'h3F);
        chk("held_fb", fbdsel, 6'h3C);

        // Randomized requests, invalid indices included.
        for (int i = 0; i < 10; i++) begin
            s = int'($urandom_range(0, 7));
            do_req(s);
        end

        // Reset in the middle of SETTLE after a change to preset 1.
        if (exp_cur == 1) do_req(0);
        bus.req_valid = 1'b1;
        bus.req_sel   = 3'd1;
        tick();
        bus.req_valid = 1'b0;
        repeat (H + 1 + 50) tick();
        chk("mid_cur", cur_sel, 1);
        chk("mid_id", idsel, 6'h3F);
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_cur = 0;
        chk("mrst_id", idsel, 6'h3D);
        chk("mrst_fb", fbdsel, 6'h32);
        chk("mrst_cur", cur_sel, 0);
        chk("mrst_hold", clk_hold, 1);
        chk("mrst_busy", busy, 1);
        chk("mrst_ready", bus.req_ready, 0);
        wait_done("mrst", S);
        tick();
        do_req(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
